// File: rtl/msel_pkg.sv
// msel_pkg -- definitions shared by the multiplier-select stream producer and
// the msel_demux receiver, so that both sides agree on the slot order and the
// product multipliers.
//   msel_state_e : receiver framing states (HUNT, COLLECT)
//   SLOT_X1..X8  : slot index of each product within a 4-slot frame
//   MUL_X3..X8   : multiplier carried in each slot
//   DW_DEFAULT   : default sampled data width
package msel_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } msel_state_e;

  localparam logic [1:0] SLOT_X1 = 2'd0;
  localparam logic [1:0] SLOT_X3 = 2'd1;
  localparam logic [1:0] SLOT_X7 = 2'd2;
  localparam logic [1:0] SLOT_X8 = 2'd3;

  localparam int MUL_X3 = 3;
  localparam int MUL_X7 = 7;
  localparam int MUL_X8 = 8;

endpackage

// File: rtl/msel_prod_check.sv
// msel_prod_check -- registered product cross-check for msel_demux.
// Compiled only when MSEL_DEMUX_CHECK_EN is defined (the only build that
// instantiates it).
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   en        : high in the cycle the last slot of a frame is captured
//   x1        : slot-0 value
//   p3/p7/p8  : full-width slot-1/2/3 words
//   dat_err   : registered mismatch flag, lands in the same cycle as vld
`ifdef MSEL_DEMUX_CHECK_EN
module msel_prod_check
  import msel_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] x1,
  input  logic [DW+2:0] p3,
  input  logic [DW+2:0] p7,
  input  logic [DW+2:0] p8,
  output logic          dat_err
);

  logic [DW+2:0] x1_w;
  logic [DW+2:0] exp3;
  logic [DW+2:0] exp7;
  logic [DW+2:0] exp8;
  logic          mismatch;
  logic          dat_err_reg;

  // Expected products by shift-add: 3x = 2x + x, 7x = 8x - x, 8x = x << 3.
  // The slot-1 word is compared at full width so a stray top bit is caught.
  assign x1_w     = {3'b000, x1};
  assign exp3     = (x1_w << 1) + x1_w;
  assign exp8     = x1_w << 3;
  assign exp7     = exp8 - x1_w;
  assign mismatch = (p3 != exp3) || (p7 != exp7) || (p8 != exp8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_err_reg <= 1'b0;
    end else begin
      dat_err_reg <= en & mismatch;
    end
  end

  assign dat_err = dat_err_reg;

endmodule
`endif

// File: rtl/msel_demux.sv
// msel_demux -- receive side of the time-multiplexed multiplier stream.
// Collects the 4-slot frame (x1, 3x1, 7x1, 8x1) framed by frame_start on
// slot 0, tracks alignment and presents the products in parallel.
// Optional feature: MSEL_DEMUX_CHECK_EN adds the product cross-check that
// drives dat_err; without it dat_err is tied low.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   frame_start  : high during slot 0 of a frame
//   din          : DW+3 bit stream word
//   vld          : one-cycle strobe, x1/x3/x7/x8 hold a new complete frame
//   x1,x3,x7,x8  : last complete frame (held between strobes)
//   sync         : receiver frame-aligned
//   frm_err      : one-cycle framing-violation pulse
//   dat_err      : one-cycle product-mismatch pulse, coincident with vld
module msel_demux
  import msel_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [DW+2:0] din,
  output logic          vld,
  output logic [DW-1:0] x1,
  output logic [DW+1:0] x3,
  output logic [DW+2:0] x7,
  output logic [DW+2:0] x8,
  output logic          sync,
  output logic          frm_err,
  output logic          dat_err
);

  msel_state_e   state_reg;
  logic [1:0]    cnt_reg;
  logic [DW-1:0] s0_reg;
  logic [DW+2:0] s1_reg;
  logic [DW+2:0] s2_reg;

  logic          vld_reg;
  logic          sync_reg;
  logic          frm_err_reg;
  logic [DW-1:0] x1_reg;
  logic [DW+1:0] x3_reg;
  logic [DW+2:0] x7_reg;
  logic [DW+2:0] x8_reg;

  logic          slot0_ok;
  logic          take_last;

  // A legal slot-0 word never uses the three extension bits.
  assign slot0_ok  = (din[DW+2:DW] == 3'b000);
  assign take_last = (state_reg == COLLECT) && !frame_start && (cnt_reg == SLOT_X8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= HUNT;
      cnt_reg     <= SLOT_X1;
      s0_reg      <= '0;
      s1_reg      <= '0;
      s2_reg      <= '0;
      vld_reg     <= 1'b0;
      sync_reg    <= 1'b0;
      frm_err_reg <= 1'b0;
      x1_reg      <= '0;
      x3_reg      <= '0;
      x7_reg      <= '0;
      x8_reg      <= '0;
    end else begin
      vld_reg     <= 1'b0;
      frm_err_reg <= 1'b0;
      if (state_reg == HUNT) begin
        if (frame_start) begin
          if (slot0_ok) begin
            s0_reg    <= din[DW-1:0];
            cnt_reg   <= SLOT_X3;
            state_reg <= COLLECT;
          end else begin
            frm_err_reg <= 1'b1;
          end
        end
      end else if (frame_start) begin
        // A start mid-frame drops the partial frame and restarts on this word.
        if (cnt_reg != SLOT_X1 || !slot0_ok) begin
          frm_err_reg <= 1'b1;
        end
        if (slot0_ok) begin
          s0_reg  <= din[DW-1:0];
          cnt_reg <= SLOT_X3;
        end else begin
          state_reg <= HUNT;
          cnt_reg   <= SLOT_X1;
          sync_reg  <= 1'b0;
        end
      end else if (cnt_reg == SLOT_X1) begin
        // Expected slot 0 but no frame_start: alignment lost.
        frm_err_reg <= 1'b1;
        sync_reg    <= 1'b0;
        state_reg   <= HUNT;
      end else begin
        case (cnt_reg)
          SLOT_X3: s1_reg <= din;
          SLOT_X7: s2_reg <= din;
          default: begin
            vld_reg  <= 1'b1;
            sync_reg <= 1'b1;
            x1_reg   <= s0_reg;
            x3_reg   <= s1_reg[DW+1:0];
            x7_reg   <= s2_reg;
            x8_reg   <= din;
          end
        endcase
        cnt_reg <= cnt_reg + 2'd1;  // slot 3 wraps back to slot 0
      end
    end
  end

`ifdef MSEL_DEMUX_CHECK_EN
  msel_prod_check #(
    .DW(DW)
  ) u_prod_check (
    .clk     (clk),
    .rst     (rst),
    .en      (take_last),
    .x1      (s0_reg),
    .p3      (s1_reg),
    .p7      (s2_reg),
    .p8      (din),
    .dat_err (dat_err)
  );
`else
  // Top bit of the slot-1 word only matters to the cross-check.
  logic unused_bits;
  assign unused_bits = s1_reg[DW+2] ^ take_last;
  assign dat_err     = 1'b0;
`endif

  assign vld     = vld_reg;
  assign sync    = sync_reg;
  assign frm_err = frm_err_reg;
  assign x1      = x1_reg;
  assign x3      = x3_reg;
  assign x7      = x7_reg;
  assign x8      = x8_reg;

endmodule
